tile_spawner: RTL and testbench

//   Consumes the free-running 4-bit random stream and places one new tile on the 4x4 2048 board.
//   - Random start cell: the first empty cell at or after that start, wrapping around the board.
//   - Random tile value: exponent 1 (tile 2) or exponent 2 (tile 4).

---
 rtl/tile_spawner_if.sv | 25 ++
 rtl/tile_spawner.sv | 101 ++++++++++
 tb/tb_tile_spawner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tile_spawner_if.sv
// Spawner request/result bundle: random stream, request and board in, status and placed tile out.
interface tile_spawner_if #(
  parameter int CELLS  = 16,
  parameter int CELL_W = 4
);
  logic [3:0]              rnd;
  logic                    spawn_req;
  logic [CELLS*CELL_W-1:0] board_in;
  logic                    busy;
  logic                    done;
  logic                    spawned;
  logic [3:0]              spawn_idx;
  logic [CELL_W-1:0]       spawn_val;
  logic [CELLS*CELL_W-1:0] board_out;

  modport master (
    output rnd, spawn_req, board_in,
    input  busy, done, spawned, spawn_idx, spawn_val, board_out
  );

  modport slave (
    input  rnd, spawn_req, board_in,
    output busy, done, spawned, spawn_idx, spawn_val, board_out
  );
endinterface

// File: rtl/tile_spawner.sv
// Places one random tile (exponent 1 or 2) into the first empty cell at or after a random start cell.
// Snapshots the board on request; result and updated board are held between done pulses.
module tile_spawner #(
  parameter int CELLS       = 16,
  parameter int CELL_W      = 4,
  parameter int RND_WAIT    = 4,
  parameter int FOUR_THRESH = 2
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESET,
  tile_spawner_if.slave sp
);
  localparam int WW = $clog2(RND_WAIT + 1);
  localparam logic [WW-1:0] W_LAST = WW'(RND_WAIT - 1);
  localparam logic [3:0]    THRESH = 4'(FOUR_THRESH);
  localparam logic [3:0]    IDX_LAST = 4'(CELLS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_WAIT, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [CELLS*CELL_W-1:0] board_lat;
  logic [CELLS*CELL_W-1:0] board_ins;
  logic [3:0]              idx;
  logic [WW-1:0]           wait_cnt;
  logic                    any_empty;
  logic [CELL_W-1:0]       cur_cell;
  logic [CELL_W-1:0]       new_val;

  always_comb begin
    any_empty = 1'b0;
    cur_cell  = '0;
    board_ins = board_lat;
    new_val   = (sp.rnd < THRESH) ? CELL_W'(2) : CELL_W'(1);
    for (int i = 0; i < CELLS; i++) begin
      if (board_lat[i*CELL_W +: CELL_W] == '0) any_empty = 1'b1;
      if (idx == 4'(i)) begin
        cur_cell = board_lat[i*CELL_W +: CELL_W];
        board_ins[i*CELL_W +: CELL_W] = new_val;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sp.spawn_req) state_nxt = S_CHECK;
      S_CHECK: state_nxt = any_empty ? S_SCAN : S_DONE;
      S_SCAN:  if (cur_cell == '0) state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == W_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sp.busy = (state != S_IDLE);
    sp.done = (state == S_DONE);
  end

  // Result outputs only change when entering DONE so they hold steady between pulses.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      board_lat    <= '0;
      idx          <= '0;
      wait_cnt     <= '0;
      sp.spawned   <= 1'b0;
      sp.spawn_idx <= '0;
      sp.spawn_val <= '0;
      sp.board_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (sp.spawn_req) board_lat <= sp.board_in;
        S_CHECK: begin
          wait_cnt <= '0;
          if (any_empty) begin
            idx <= sp.rnd;
          end else begin
            sp.spawned   <= 1'b0;
            sp.board_out <= board_lat;
          end
        end
        S_SCAN: if (cur_cell != '0) idx <= (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
        S_WAIT: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (wait_cnt == W_LAST) begin
            sp.spawned   <= 1'b1;
            sp.spawn_idx <= idx;
            sp.spawn_val <= new_val;
            sp.board_out <= board_ins;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_spawner.sv
// Directed checks of tile_spawner: placement, wrap, tile value, full board, snapshot, reset and drops.
module tb_tile_spawner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  tile_spawner_if #(.CELLS(16), .CELL_W(4)) bus ();

  tile_spawner dut (
    .CLK100MHZ(clk),
    .CPU_RESET(rst),
    .sp       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Request at edge N; rnd_late replaces rnd after the CHECK edge. Returns done latency in cycles (0 = none).
  task automatic run_spawn(input logic [63:0] brd, input logic [3:0] rnd0, input logic [3:0] rnd_late,
                           input bit tamper, output int lat);
    lat = 0;
    @(posedge clk); #1;
    bus.board_in  = brd;
    bus.rnd       = rnd0;
    bus.spawn_req = 1'b1;
    @(posedge clk); #1;
    bus.spawn_req = 1'b0;
    if (tamper) bus.board_in = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int m = 1; m <= 40; m++) begin
      @(negedge clk);
      if (m == 2) bus.rnd = rnd_late;
      if (bus.done) begin
        lat = m;
        break;
      end
    end
  endtask

  int lat;
  int dones;

  initial begin
    bus.rnd       = 4'h0;
    bus.spawn_req = 1'b0;
    bus.board_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_board_out", bus.board_out, 64'd0);
    rst = 1'b0;

    // 1: empty board, rnd 5
    run_spawn(64'h0, 4'h5, 4'h5, 1'b0, lat);
    chk("t1_lat", 64'(lat), 64'd7);
    chk("t1_idx", 64'(bus.spawn_idx), 64'd5);
    chk("t1_val", 64'(bus.spawn_val), 64'd1);
    chk("t1_spawned", 64'(bus.spawned), 64'd1);
    chk("t1_board", bus.board_out, 64'h0000_0000_0010_0000);

    // 2: cells 5,6 occupied; board_in tampered after acceptance
    run_spawn(64'h0000_0000_0330_0000, 4'h5, 4'h5, 1'b1, lat);
    chk("t2_lat", 64'(lat), 64'd9);
    chk("t2_idx", 64'(bus.spawn_idx), 64'd7);
    chk("t2_board", bus.board_out, 64'h0000_0000_1330_0000);
    @(negedge clk);
    chk("t2_hold_board", bus.board_out, 64'h0000_0000_1330_0000);
    chk("t2_idle", 64'(bus.busy), 64'd0);

    // 3: wrap 15 -> 0
    run_spawn(64'h1111_1111_1111_1110, 4'hF, 4'hF, 1'b0, lat);
    chk("t3_lat", 64'(lat), 64'd8);
    chk("t3_idx", 64'(bus.spawn_idx), 64'd0);
    chk("t3_board", bus.board_out, 64'h1111_1111_1111_1111);

    // 4: value from fresh rnd below threshold
    run_spawn(64'h0, 4'h5, 4'h1, 1'b0, lat);
    chk("t4_lat", 64'(lat), 64'd7);
    chk("t4_idx", 64'(bus.spawn_idx), 64'd5);
    chk("t4_val", 64'(bus.spawn_val), 64'd2);
    chk("t4_board", bus.board_out, 64'h0000_0000_0020_0000);

    // 5: full board
    run_spawn(64'h3333_3333_3333_3333, 4'h5, 4'h5, 1'b0, lat);
    chk("t5_lat", 64'(lat), 64'd2);
    chk("t5_spawned", 64'(bus.spawned), 64'd0);
    chk("t5_board", bus.board_out, 64'h3333_3333_3333_3333);
    chk("t5_keep_idx", 64'(bus.spawn_idx), 64'd5);
    chk("t5_keep_val", 64'(bus.spawn_val), 64'd2);
    @(negedge clk);
    chk("t5_busy_low", 64'(bus.busy), 64'd0);

    // 6: reset in WAIT abandons the spawn
    @(posedge clk); #1;
    bus.board_in  = 64'h0;
    bus.rnd       = 4'h5;
    bus.spawn_req = 1'b1;
    @(posedge clk); #1;
    bus.spawn_req = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    chk("t6_rst_done", 64'(bus.done), 64'd0);
    chk("t6_rst_spawned", 64'(bus.spawned), 64'd0);
    chk("t6_rst_idx", 64'(bus.spawn_idx), 64'd0);
    chk("t6_rst_val", 64'(bus.spawn_val), 64'd0);
    chk("t6_rst_board", bus.board_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("t6_no_done", 64'(dones), 64'd0);

    // Request at N, second request at N+3 while busy
    @(posedge clk); #1;
    bus.board_in  = 64'h0000_0000_0000_0300;
    bus.rnd       = 4'h2;
    bus.spawn_req = 1'b1;
    @(posedge clk); #1;
    bus.spawn_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.spawn_req = 1'b1;
    @(posedge clk); #1;
    bus.spawn_req = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("t6_one_done", 64'(dones), 64'd1);
    chk("t6_idx", 64'(bus.spawn_idx), 64'd3);
    chk("t6_board", bus.board_out, 64'h0000_0000_0000_1300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
